// File: rtl/ysyx_25020037_wbu.sv
// Write-back unit: holds one LSU result, formats load data, writes RF/CSR for one
// cycle, then presents a commit record and counts retired non-faulting instructions.
module ysyx_25020037_wbu #(
  parameter int CNT_WD = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_valid,
  output logic              wbu_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_dnpc,
  input  logic [4:0]        in_rd,
  input  logic              in_rf_we,
  input  logic              in_is_load,
  input  logic [2:0]        in_load_op,
  input  logic              in_load_unsigned,
  input  logic [1:0]        in_addr_off,
  input  logic [31:0]       in_rdata,
  input  logic [31:0]       in_alu_result,
  input  logic              in_csr_we,
  input  logic [11:0]       in_csr_addr,
  input  logic [31:0]       in_csr_wdata,
  input  logic              in_access_fault,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              csr_we,
  output logic [11:0]       csr_waddr,
  output logic [31:0]       csr_wdata,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [31:0]       commit_pc,
  output logic [31:0]       commit_dnpc,
  output logic              commit_fault,
  output logic [1:0]        commit_cause,
  output logic [CNT_WD-1:0] minstret
);

  typedef enum logic [1:0] {IDLE, WB, COMMIT} state_t;

  state_t state, state_nxt;

  logic [31:0] pc_p0, dnpc_p0, rdata_p0, alu_result_p0, csr_wdata_p0;
  logic [4:0]  rd_p0;
  logic [2:0]  load_op_p0;
  logic [1:0]  addr_off_p0;
  logic [11:0] csr_addr_p0;
  logic        rf_we_p0, is_load_p0, load_unsigned_p0, csr_we_p0, access_fault_p0;

  logic accept, misalign, in_wb, commit_fire;
  logic [31:0] load_data;

  function automatic logic [31:0] fmt_load(input logic [2:0] op, input logic uns,
                                           input logic [1:0] off, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (op)
      3'b001:  fmt_load = uns ? {24'd0, b} : {{24{b[7]}}, b};
      3'b010:  fmt_load = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: fmt_load = rdata;
    endcase
  endfunction

  // Any encoding other than byte/half is a word access and must be 4-byte aligned.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      3'b001:  is_misaligned = 1'b0;
      3'b010:  is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

  assign wbu_ready = (state == IDLE);
  assign accept    = lsu_valid & wbu_ready;

  // Stage p0: holding registers captured on the accept edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_p0            <= '0;
      dnpc_p0          <= '0;
      rd_p0            <= '0;
      rf_we_p0         <= 1'b0;
      is_load_p0       <= 1'b0;
      load_op_p0       <= '0;
      load_unsigned_p0 <= 1'b0;
      addr_off_p0      <= '0;
      rdata_p0         <= '0;
      alu_result_p0    <= '0;
      csr_we_p0        <= 1'b0;
      csr_addr_p0      <= '0;
      csr_wdata_p0     <= '0;
      access_fault_p0  <= 1'b0;
    end else if (accept) begin
      pc_p0            <= in_pc;
      dnpc_p0          <= in_dnpc;
      rd_p0            <= in_rd;
      rf_we_p0         <= in_rf_we;
      is_load_p0       <= in_is_load;
      load_op_p0       <= in_load_op;
      load_unsigned_p0 <= in_load_unsigned;
      addr_off_p0      <= in_addr_off;
      rdata_p0         <= in_rdata;
      alu_result_p0    <= in_alu_result;
      csr_we_p0        <= in_csr_we;
      csr_addr_p0      <= in_csr_addr;
      csr_wdata_p0     <= in_csr_wdata;
      access_fault_p0  <= in_access_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (lsu_valid) state_nxt = WB;
      WB:      state_nxt = COMMIT;
      COMMIT:  if (commit_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign load_data    = fmt_load(load_op_p0, load_unsigned_p0, addr_off_p0, rdata_p0);
  assign misalign     = is_load_p0 & is_misaligned(load_op_p0, addr_off_p0);
  assign commit_fault = access_fault_p0 | misalign;
  assign commit_cause = access_fault_p0 ? 2'b01 : (misalign ? 2'b10 : 2'b00);

  // Enables also gated by rst so a write coinciding with the reset edge never lands.
  assign in_wb     = (state == WB) & rst;
  assign rf_we     = in_wb & rf_we_p0 & (rd_p0 != 5'd0) & ~commit_fault;
  assign rf_waddr  = rd_p0;
  assign rf_wdata  = is_load_p0 ? load_data : alu_result_p0;
  assign csr_we    = in_wb & csr_we_p0 & ~commit_fault;
  assign csr_waddr = csr_addr_p0;
  assign csr_wdata = csr_wdata_p0;

  assign commit_valid = (state == COMMIT);
  assign commit_pc    = pc_p0;
  assign commit_dnpc  = dnpc_p0;
  assign commit_fire  = commit_valid & commit_ready;

  always_ff @(posedge clk) begin
    if (!rst)                              minstret <= '0;
    else if (commit_fire && !commit_fault) minstret <= minstret + CNT_WD'(1);
  end

endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
// Bench for ysyx_25020037_wbu: vector table driven through a commit scoreboard,
// plus hand sequences for backpressure, counter wrap and reset during WB.
module tb_ysyx_25020037_wbu;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst, lsu_valid, wbu_ready;
  logic [31:0] in_pc, in_dnpc, in_rdata, in_alu_result, in_csr_wdata;
  logic [4:0]  in_rd;
  logic        in_rf_we, in_is_load, in_load_unsigned, in_csr_we, in_access_fault;
  logic [2:0]  in_load_op;
  logic [1:0]  in_addr_off;
  logic [11:0] in_csr_addr;
  logic        rf_we, csr_we, commit_valid, commit_ready, commit_fault;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, csr_wdata, commit_pc, commit_dnpc;
  logic [11:0] csr_waddr;
  logic [1:0]  commit_cause;
  logic [CW-1:0] minstret;

  ysyx_25020037_wbu #(.CNT_WD(CW)) dut (
    .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .wbu_ready(wbu_ready),
    .in_pc(in_pc), .in_dnpc(in_dnpc), .in_rd(in_rd), .in_rf_we(in_rf_we),
    .in_is_load(in_is_load), .in_load_op(in_load_op), .in_load_unsigned(in_load_unsigned),
    .in_addr_off(in_addr_off), .in_rdata(in_rdata), .in_alu_result(in_alu_result),
    .in_csr_we(in_csr_we), .in_csr_addr(in_csr_addr), .in_csr_wdata(in_csr_wdata),
    .in_access_fault(in_access_fault),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_pc(commit_pc),
    .commit_dnpc(commit_dnpc), .commit_fault(commit_fault), .commit_cause(commit_cause),
    .minstret(minstret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rf_we, is_load;
    logic [2:0]  op;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] rdata, alu;
    logic        csr_we;
    logic [11:0] caddr;
    logic [31:0] cdata;
    logic        afault;
    logic        e_rf_we;
    logic [31:0] e_wdata;
    logic        chk_data, e_csr_we, e_fault;
    logic [1:0]  e_cause;
  } vec_t;

  typedef struct {
    logic [31:0] pc, dnpc;
    logic        fault;
    logic [1:0]  cause;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[16];
  int total = 0;
  int bad = 0;
  logic [CW-1:0] exp_minstret = '0;

  function automatic vec_t mk(input logic [4:0] rd, input logic rfw, input logic ld,
      input logic [2:0] op, input logic uns, input logic [1:0] off, input logic [31:0] rdata,
      input logic [31:0] alu, input logic cw, input logic [11:0] ca, input logic [31:0] cd,
      input logic af, input logic erw, input logic [31:0] ewd, input logic chk,
      input logic ecw, input logic ef, input logic [1:0] ec);
    vec_t v;
    v.rd = rd; v.rf_we = rfw; v.is_load = ld; v.op = op; v.uns = uns; v.off = off;
    v.rdata = rdata; v.alu = alu; v.csr_we = cw; v.caddr = ca; v.cdata = cd; v.afault = af;
    v.e_rf_we = erw; v.e_wdata = ewd; v.chk_data = chk; v.e_csr_we = ecw;
    v.e_fault = ef; v.e_cause = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic [31:0] pc);
    in_pc = pc; in_dnpc = pc + 32'd4; in_rd = v.rd; in_rf_we = v.rf_we;
    in_is_load = v.is_load; in_load_op = v.op; in_load_unsigned = v.uns;
    in_addr_off = v.off; in_rdata = v.rdata; in_alu_result = v.alu;
    in_csr_we = v.csr_we; in_csr_addr = v.caddr; in_csr_wdata = v.cdata;
    in_access_fault = v.afault;
  endtask

  // Called on a negedge; returns on a negedge after the commit handshake.
  task automatic do_txn(input vec_t v, input logic [31:0] pc, input int bp);
    exp_t e, got;
    int cnt;
    cnt = 0;
    while (!wbu_ready && cnt < 20) begin @(negedge clk); cnt++; end
    if (!wbu_ready) begin chk("ready_timeout", 32'(wbu_ready), 32'd1); return; end
    drive(v, pc);
    lsu_valid = 1'b1;
    commit_ready = (bp == 0);
    e.pc = pc; e.dnpc = pc + 32'd4; e.fault = v.e_fault; e.cause = v.e_cause;
    sbq.push_back(e);
    @(negedge clk);
    lsu_valid = 1'b0;
    chk("wb_ready_low", 32'(wbu_ready), 32'd0);
    chk("wb_rf_we", 32'(rf_we), 32'(v.e_rf_we));
    chk("wb_csr_we", 32'(csr_we), 32'(v.e_csr_we));
    if (v.e_rf_we) chk("wb_rf_waddr", 32'(rf_waddr), 32'(v.rd));
    if (v.chk_data) chk("wb_rf_wdata", rf_wdata, v.e_wdata);
    if (v.e_csr_we) begin
      chk("wb_csr_waddr", 32'(csr_waddr), 32'(v.caddr));
      chk("wb_csr_wdata", csr_wdata, v.cdata);
    end
    @(negedge clk);
    cnt = 0;
    while (!commit_valid && cnt < 10) begin @(negedge clk); cnt++; end
    if (!commit_valid) begin chk("commit_timeout", 32'(commit_valid), 32'd1); return; end
    if (sbq.size() == 0) begin chk("sb_empty", 32'd0, 32'd1); return; end
    got = sbq.pop_front();
    chk("rf_we_after_wb", 32'(rf_we), 32'd0);
    chk("csr_we_after_wb", 32'(csr_we), 32'd0);
    for (int i = 0; i < bp; i++) begin
      in_pc = 32'hBAD0_0000; lsu_valid = 1'b1;
      chk("bp_valid", 32'(commit_valid), 32'd1);
      chk("bp_ready_low", 32'(wbu_ready), 32'd0);
      chk("bp_pc", commit_pc, got.pc);
      @(negedge clk);
    end
    lsu_valid = 1'b0;
    commit_ready = 1'b1;
    chk("commit_pc", commit_pc, got.pc);
    chk("commit_dnpc", commit_dnpc, got.dnpc);
    chk("commit_fault", 32'(commit_fault), 32'(got.fault));
    chk("commit_cause", 32'(commit_cause), 32'(got.cause));
    @(negedge clk);
    if (!got.fault) exp_minstret = exp_minstret + 1'b1;
    chk("post_idle_ready", 32'(wbu_ready), 32'd1);
    chk("post_commit_valid", 32'(commit_valid), 32'd0);
    chk("minstret", 32'(minstret), 32'(exp_minstret));
    if (bp > 0) chk("bp_no_capture", commit_pc, got.pc);
  endtask

  initial begin
    tbl[0]  = mk(5'd5,  1, 1, 3'b001, 0, 2'd1, 32'h1234_80FF, 0, 0, 0, 0, 0, 1, 32'hFFFF_FF80, 1, 0, 0, 2'b00);
    tbl[1]  = mk(5'd6,  1, 1, 3'b010, 1, 2'd2, 32'h8001_0000, 0, 0, 0, 0, 0, 1, 32'h0000_8001, 1, 0, 0, 2'b00);
    tbl[2]  = mk(5'd7,  1, 1, 3'b100, 0, 2'd1, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 2'b10);
    tbl[3]  = mk(5'd7,  1, 1, 3'b100, 0, 2'd1, 32'hCAFE_F00D, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 1, 2'b01);
    tbl[4]  = mk(5'd0,  1, 0, 3'b000, 0, 2'd0, 32'h0, 32'hDEAD_BEEF, 1, 12'h300, 32'h8, 0, 0, 32'hDEAD_BEEF, 1, 1, 0, 2'b00);
    tbl[5]  = mk(5'd8,  1, 1, 3'b001, 1, 2'd3, 32'hA500_0000, 0, 0, 0, 0, 0, 1, 32'h0000_00A5, 1, 0, 0, 2'b00);
    tbl[6]  = mk(5'd9,  1, 1, 3'b010, 0, 2'd0, 32'h0000_F00D, 0, 0, 0, 0, 0, 1, 32'hFFFF_F00D, 1, 0, 0, 2'b00);
    tbl[7]  = mk(5'd10, 1, 1, 3'b100, 0, 2'd0, 32'h8765_4321, 0, 0, 0, 0, 0, 1, 32'h8765_4321, 1, 0, 0, 2'b00);
    tbl[8]  = mk(5'd11, 1, 1, 3'b011, 0, 2'd0, 32'h1122_3344, 0, 0, 0, 0, 0, 1, 32'h1122_3344, 1, 0, 0, 2'b00);
    tbl[9]  = mk(5'd12, 1, 1, 3'b000, 0, 2'd2, 32'h1122_3344, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 2'b10);
    tbl[10] = mk(5'd13, 1, 1, 3'b010, 0, 2'd3, 32'h1122_3344, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 2'b10);
    tbl[11] = mk(5'd14, 1, 0, 3'b000, 0, 2'd0, 32'h0, 32'h1234_5678, 1, 12'h341, 32'h55, 1, 0, 32'h1234_5678, 1, 0, 1, 2'b01);
    tbl[12] = mk(5'd15, 1, 1, 3'b001, 0, 2'd2, 32'h007F_0000, 0, 0, 0, 0, 0, 1, 32'h0000_007F, 1, 0, 0, 2'b00);
    tbl[13] = mk(5'd16, 1, 1, 3'b010, 0, 2'd2, 32'h8001_0000, 0, 0, 0, 0, 0, 1, 32'hFFFF_8001, 1, 0, 0, 2'b00);
    tbl[14] = mk(5'd17, 0, 0, 3'b000, 0, 2'd0, 32'h0, 32'h0000_0001, 0, 0, 0, 0, 0, 32'h0000_0001, 1, 0, 0, 2'b00);
    tbl[15] = mk(5'd18, 1, 1, 3'b111, 1, 2'd0, 32'hFFFF_0000, 0, 0, 0, 0, 0, 1, 32'hFFFF_0000, 1, 0, 0, 2'b00);

    rst = 1'b0; lsu_valid = 1'b0; commit_ready = 1'b1;
    drive(tbl[0], 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(wbu_ready), 32'd1);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_csr_we", 32'(csr_we), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_commit_pc", commit_pc, 32'd0);
    chk("rst_minstret", 32'(minstret), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) do_txn(tbl[i], 32'h8000_0000 + 32'(i * 4), 0);

    do_txn(tbl[0], 32'h8000_1000, 5);

    while (exp_minstret != '1) do_txn(tbl[7], 32'h8000_2000, 0);
    chk("minstret_all_ones", 32'(minstret), 32'hF);
    do_txn(tbl[7], 32'h8000_2004, 0);
    chk("minstret_wrap", 32'(minstret), 32'd0);

    drive(tbl[0], 32'h8000_3000);
    lsu_valid = 1'b1;
    @(negedge clk);
    lsu_valid = 1'b0;
    chk("rst_wb_pre_we", 32'(rf_we), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    exp_minstret = '0;
    chk("rst_wb_rf_we", 32'(rf_we), 32'd0);
    chk("rst_wb_ready", 32'(wbu_ready), 32'd1);
    chk("rst_wb_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_wb_wdata", rf_wdata, 32'd0);
    chk("rst_wb_minstret", 32'(minstret), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wb_no_commit", 32'(commit_valid), 32'd0);
    do_txn(tbl[1], 32'h8000_4000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
